// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response, issue handshake and
// redirect/halt signals. The fetch unit takes the master side.
interface inst_fetch_queue_if #(
    parameter int WORD_SIZE = 32
);
    logic                 imem_req;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_valid;
    logic [WORD_SIZE-1:0] imem_data;
    logic                 issue_valid;
    logic [WORD_SIZE-1:0] issue_inst;
    logic [WORD_SIZE-1:0] issue_pc;
    logic                 issue_ready;
    logic                 flush;
    logic [WORD_SIZE-1:0] flush_pc;
    logic                 halted;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data,
        output issue_valid,
        output issue_inst,
        output issue_pc,
        input  issue_ready,
        input  flush,
        input  flush_pc,
        output halted
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data,
        input  issue_valid,
        input  issue_inst,
        input  issue_pc,
        output issue_ready,
        output flush,
        output flush_pc,
        input  halted
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one outstanding memory request at a time, an
// in-order FIFO of {inst, pc} toward issue, flush redirect and HALT stop.
module inst_fetch_queue #(
    parameter int                      WORD_SIZE    = 32,
    parameter int                      OPCODE_WIDTH = 6,
    parameter int                      QUEUE_DEPTH  = 4,
    parameter logic [WORD_SIZE-1:0]    RESET_PC     = '0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OP      = 6'h3f
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_queue_if.master bus
);

    localparam int                PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);

    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("inst_fetch_queue: QUEUE_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD,
        S_HALTED
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 halted_q, halted_d;

    logic [WORD_SIZE-1:0] inst_mem_q [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0] pc_mem_q   [QUEUE_DEPTH];

    logic head_valid;
    logic req;
    logic enq;
    logic deq;
    logic outstanding;
    logic is_halt;

    // Handshake decode; flush suppresses every queue and request side effect.
    always_comb begin
        head_valid  = (count_q != '0);
        outstanding = (state_q == S_WAIT) || (state_q == S_DISCARD);
        req         = reset && (state_q == S_FETCH) && (count_q < DEPTH_C) && !bus.flush;
        enq         = (state_q == S_WAIT) && bus.imem_valid && !bus.flush;
        deq         = head_valid && bus.issue_ready && !bus.flush;
        is_halt     = (bus.imem_data[WORD_SIZE-1 -: OPCODE_WIDTH] == HALT_OP);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        halted_d = halted_q;

        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = bus.flush_pc;
            halted_d = 1'b0;
            // A response still owed by memory must be swallowed before refetching.
            state_d  = (outstanding && !bus.imem_valid) ? S_DISCARD : S_FETCH;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

            unique case (state_q)
                S_FETCH: begin
                    if (req) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + WORD_SIZE'(1);
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_valid) begin
                        if (is_halt) begin
                            state_d  = S_HALTED;
                            halted_d = 1'b1;
                        end else begin
                            state_d  = S_FETCH;
                        end
                    end
                end
                S_DISCARD: begin
                    if (bus.imem_valid) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            halted_q <= halted_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_data;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.issue_valid = head_valid;
    assign bus.issue_inst  = head_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign bus.issue_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a variable-latency memory responder plus a
// queue-based reference model of the fetch stream, checked every cycle.
module tb_inst_fetch_queue;
    localparam int            WS     = 32;
    localparam int            DEPTH  = 4;
    localparam logic [WS-1:0] RST_PC = '0;
    localparam logic [5:0]    HALT   = 6'h3f;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_fetch_queue_if #(.WORD_SIZE(WS)) dut_if ();

    inst_fetch_queue #(
        .WORD_SIZE(WS), .OPCODE_WIDTH(6), .QUEUE_DEPTH(DEPTH),
        .RESET_PC(RST_PC), .HALT_OP(HALT)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(dut_if.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: expected FIFO contents plus fetch bookkeeping.
    logic [63:0]   exp_q[$];
    logic [WS-1:0] m_pc, m_pend_pc;
    bit            m_pend, m_stale, m_halted;

    // Memory responder.
    bit            mem_busy;
    int            mem_cnt;
    logic [WS-1:0] mem_addr;
    int            lat = 1;
    bit            rnd_lat, rnd_data, inj;
    logic [WS-1:0] halt_addr = '1;

    bit            cur_fl, cur_rdy;
    logic [WS-1:0] cur_fpc;

    logic [WS-1:0] log_pc[$];
    logic [WS-1:0] log_inst[$];
    int            log_cyc[$];

    function automatic logic [WS-1:0] word_of(input logic [WS-1:0] a);
        logic [WS-1:0] w;
        if (a == halt_addr) begin
            w = {HALT, a[25:0]};
        end else if (rnd_data) begin
            w = $urandom;
        end else begin
            w = a + 32'h100;
        end
        return w;
    endfunction

    function automatic bit exp_req();
        return rst_n && !cur_fl && !m_halted && !m_pend && !m_stale && (exp_q.size() < DEPTH);
    endfunction

    function automatic logic [98:0] want();
        logic          ev, er;
        logic [WS-1:0] hp, hi, ea;
        ev = (exp_q.size() != 0);
        hp = ev ? exp_q[0][63:32] : '0;
        hi = ev ? exp_q[0][31:0] : '0;
        er = exp_req();
        ea = er ? m_pc : '0;
        return {ev, hp, hi, er, ea, m_halted};
    endfunction

    function automatic logic [98:0] snap();
        logic v, r;
        v = dut_if.issue_valid;
        r = dut_if.imem_req;
        return {v, v ? dut_if.issue_pc : '0, v ? dut_if.issue_inst : '0,
                r, r ? dut_if.imem_addr : '0, dut_if.halted};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc     = RST_PC;
        m_pend   = 1'b0;
        m_stale  = 1'b0;
        m_halted = 1'b0;
        mem_busy = 1'b0;
    endtask

    // Called at a falling edge: apply this cycle's inputs and let them settle.
    task automatic drive(input bit fl, input logic [WS-1:0] fpc, input bit rdy);
        cur_fl  = fl;
        cur_fpc = fpc;
        cur_rdy = rdy;
        dut_if.flush       = fl;
        dut_if.flush_pc    = fpc;
        dut_if.issue_ready = rdy;
        dut_if.imem_valid  = 1'b0;
        dut_if.imem_data   = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                dut_if.imem_valid = 1'b1;
                dut_if.imem_data  = word_of(mem_addr);
                mem_busy = 1'b0;
            end
        end else if (inj) begin
            dut_if.imem_valid = 1'b1;
            dut_if.imem_data  = 32'hDC00_BEEF;
            inj = 1'b0;
        end
        #1;
    endtask

    // Accept any request, log fired heads, step the model, move to next falling edge.
    task automatic advance();
        bit            er;
        bit            iv;
        logic [WS-1:0] id;
        er = exp_req();
        iv = dut_if.imem_valid;
        id = dut_if.imem_data;
        if (rst_n && dut_if.imem_req) begin
            n_chk++;
            if (exp_q.size() >= DEPTH) begin
                n_fail++;
                $display("FAIL req_room cyc=%0d queued=%0d required<%0d", cyc, exp_q.size(), DEPTH);
            end
            mem_busy = 1'b1;
            mem_cnt  = rnd_lat ? int'($urandom_range(1, 4)) : lat;
            mem_addr = dut_if.imem_addr;
        end
        if (rst_n && dut_if.issue_valid && cur_rdy && !cur_fl) begin
            log_pc.push_back(dut_if.issue_pc);
            log_inst.push_back(dut_if.issue_inst);
            log_cyc.push_back(cyc);
        end
        if (rst_n) begin
            if (cur_fl) begin
                exp_q.delete();
                m_pc     = cur_fpc;
                m_halted = 1'b0;
                m_stale  = (m_pend || m_stale) && !iv;
                m_pend   = 1'b0;
            end else begin
                if (exp_q.size() > 0 && cur_rdy) void'(exp_q.pop_front());
                if (m_pend && iv) begin
                    exp_q.push_back({m_pend_pc, id});
                    m_pend = 1'b0;
                    if (id[31:26] == HALT) m_halted = 1'b1;
                end else if (m_stale && iv) begin
                    m_stale = 1'b0;
                end
                if (er) begin
                    m_pend    = 1'b1;
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        inj = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0);
            advance();
        end
        rst_n = 1'b1;
        log_pc.delete();
        log_inst.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, '0, 1'b0);
        n_chk++;
        if ({dut_if.issue_valid, dut_if.issue_inst, dut_if.issue_pc, dut_if.imem_req, dut_if.halted} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b inst=%h pc=%h req=%b halted=%b want all zero",
                     dut_if.issue_valid, dut_if.issue_inst, dut_if.issue_pc, dut_if.imem_req, dut_if.halted);
        end
        advance();
        drive(1'b0, '0, 1'b0);
        advance();
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1);
        n_chk++;
        if (!(dut_if.imem_req === 1'b1 && dut_if.imem_addr === RST_PC)) begin
            n_fail++;
            $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", dut_if.imem_req, dut_if.imem_addr, RST_PC);
        end
        n_chk++;
        if (snap() !== want()) begin n_fail++; $display("FAIL reset_cycle cyc=%0d got=%h want=%h", cyc, snap(), want()); end
        advance();
    endtask

    task automatic test_stream();
        lat = 1; rnd_lat = 0; rnd_data = 0; halt_addr = '1;
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL stream cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        n_chk++;
        if (log_pc.size() < 4) begin
            n_fail++;
            $display("FAIL stream_count got=%0d issued want>=4", log_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (log_pc[i] !== 32'(i) || log_inst[i] !== 32'h100 + 32'(i)) begin
                    n_fail++;
                    $display("FAIL stream_order[%0d] got pc=%h inst=%h want pc=%h inst=%h",
                             i, log_pc[i], log_inst[i], 32'(i), 32'h100 + 32'(i));
                end
                if (i > 0) begin
                    n_chk++;
                    if (log_cyc[i] - log_cyc[i-1] != 2) begin
                        n_fail++;
                        $display("FAIL stream_spacing[%0d] got=%0d cycles want=2", i, log_cyc[i] - log_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        lat = 1; rnd_lat = 0; rnd_data = 0; halt_addr = '1;
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b0);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL backpressure cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        drive(1'b0, '0, 1'b0);
        n_chk++;
        if (!(dut_if.issue_valid === 1'b1 && dut_if.issue_pc === 32'd0 && dut_if.imem_req === 1'b0)) begin
            n_fail++;
            $display("FAIL bp_full got v=%b pc=%h req=%b want v=1 pc=0 req=0", dut_if.issue_valid, dut_if.issue_pc, dut_if.imem_req);
        end
        advance();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL bp_drain cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (i >= log_pc.size() || log_pc[i] !== 32'(i)) begin
                n_fail++;
                $display("FAIL bp_order[%0d] got=%h want=%h", i, (i < log_pc.size()) ? log_pc[i] : 32'hXXXXXXXX, 32'(i));
            end
        end
    endtask

    task automatic test_flush_discard();
        bit found, seen, stale;
        lat = 3; rnd_lat = 0; rnd_data = 0; halt_addr = '1;
        do_reset(2);
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL flush_pre cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            if (dut_if.imem_req && dut_if.imem_addr == 32'd5) found = 1;
            advance();
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL flush_setup got no request to pc 5 within 80 cycles want one");
            return;
        end
        drive(1'b1, 32'h40, 1'b1);
        n_chk++;
        if (snap() !== want()) begin n_fail++; $display("FAIL flush_cycle cyc=%0d got=%h want=%h", cyc, snap(), want()); end
        advance();
        log_pc.delete(); log_inst.delete(); log_cyc.delete();
        drive(1'b0, '0, 1'b1);
        n_chk++;
        if (dut_if.issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clears got issue_valid=%b want 0", dut_if.issue_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL flush_post cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            if (!seen && dut_if.imem_req) begin
                seen = 1;
                n_chk++;
                if (dut_if.imem_addr !== 32'h40) begin
                    n_fail++;
                    $display("FAIL flush_first_req got addr=%h want 00000040", dut_if.imem_addr);
                end
            end
            advance();
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL flush_no_req got no request in 20 cycles want request to 00000040"); end
        stale = 0;
        foreach (log_pc[k]) if (log_pc[k] == 32'd5) stale = 1;
        n_chk++;
        if (stale) begin n_fail++; $display("FAIL stale_not_issued got pc 5 issued after flush want never"); end
    endtask

    task automatic test_halt();
        lat = 1; rnd_lat = 0; rnd_data = 0; halt_addr = 32'd2;
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL halt_run cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        halt_addr = '1;
        drive(1'b0, '0, 1'b1);
        n_chk++;
        if (!(dut_if.halted === 1'b1 && dut_if.issue_valid === 1'b0 && dut_if.imem_req === 1'b0)) begin
            n_fail++;
            $display("FAIL halt_state got halted=%b v=%b req=%b want halted=1 v=0 req=0",
                     dut_if.halted, dut_if.issue_valid, dut_if.imem_req);
        end
        n_chk++;
        if (log_pc.size() != 3) begin
            n_fail++;
            $display("FAIL halt_count got=%0d issued want=3", log_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (log_pc[i] !== 32'(i)) begin n_fail++; $display("FAIL halt_order[%0d] got=%h want=%h", i, log_pc[i], 32'(i)); end
            end
        end
        advance();
        drive(1'b1, 32'h10, 1'b1);
        n_chk++;
        if (snap() !== want()) begin n_fail++; $display("FAIL halt_flush cyc=%0d got=%h want=%h", cyc, snap(), want()); end
        advance();
        drive(1'b0, '0, 1'b1);
        n_chk++;
        if (!(dut_if.halted === 1'b0 && dut_if.imem_req === 1'b1 && dut_if.imem_addr === 32'h10)) begin
            n_fail++;
            $display("FAIL halt_resume got halted=%b req=%b addr=%h want halted=0 req=1 addr=00000010",
                     dut_if.halted, dut_if.imem_req, dut_if.imem_addr);
        end
        advance();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL halt_after cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        bit ready;
        lat = 2; rnd_lat = 0; rnd_data = 0; halt_addr = '1;
        do_reset(2);
        ready = 0;
        for (int i = 0; i < 40 && !ready; i++) begin
            drive(1'b0, '0, 1'b0);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL rmid_pre cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
            if (exp_q.size() == 2 && m_pend) ready = 1;
        end
        n_chk++;
        if (!ready) begin n_fail++; $display("FAIL rmid_setup got no 2-entry WAIT within 40 cycles want one"); return; end
        drive(1'b0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (!(dut_if.issue_valid === 1'b0 && dut_if.imem_req === 1'b0 && dut_if.halted === 1'b0)) begin
            n_fail++;
            $display("FAIL reset_async got v=%b req=%b halted=%b want all 0", dut_if.issue_valid, dut_if.imem_req, dut_if.halted);
        end
        model_reset();
        advance();
        drive(1'b0, '0, 1'b0);
        n_chk++;
        if (snap() !== want()) begin n_fail++; $display("FAIL rmid_hold cyc=%0d got=%h want=%h", cyc, snap(), want()); end
        advance();
        inj = 1'b1;
        rst_n = 1'b1;
        log_pc.delete(); log_inst.delete(); log_cyc.delete();
        drive(1'b0, '0, 1'b1);
        n_chk++;
        if (!(dut_if.imem_req === 1'b1 && dut_if.imem_addr === RST_PC)) begin
            n_fail++;
            $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=%h", dut_if.imem_req, dut_if.imem_addr, RST_PC);
        end
        advance();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL rmid_post cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        n_chk++;
        if (log_pc.size() == 0 || log_pc[0] !== RST_PC || log_inst[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL reset_no_stale got first pc=%h inst=%h want pc=%h inst=00000100",
                     (log_pc.size() != 0) ? log_pc[0] : 32'hXXXXXXXX, (log_inst.size() != 0) ? log_inst[0] : 32'hXXXXXXXX, RST_PC);
        end
    endtask

    task automatic test_flush_collide();
        bit ready;
        lat = 1; rnd_lat = 0; rnd_data = 0; halt_addr = '1;
        do_reset(2);
        ready = 0;
        for (int i = 0; i < 40 && !ready; i++) begin
            drive(1'b0, '0, 1'b0);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL collide_pre cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
            if (exp_q.size() == 2 && m_pend) ready = 1;
        end
        n_chk++;
        if (!ready) begin n_fail++; $display("FAIL collide_setup got no 2-entry WAIT within 40 cycles want one"); return; end
        drive(1'b1, 32'h80, 1'b1);
        n_chk++;
        if (snap() !== want()) begin n_fail++; $display("FAIL collide_cycle cyc=%0d got=%h want=%h", cyc, snap(), want()); end
        advance();
        log_pc.delete(); log_inst.delete(); log_cyc.delete();
        drive(1'b0, '0, 1'b1);
        n_chk++;
        if (!(dut_if.issue_valid === 1'b0 && dut_if.imem_req === 1'b1 && dut_if.imem_addr === 32'h80)) begin
            n_fail++;
            $display("FAIL collide_empty got v=%b req=%b addr=%h want v=0 req=1 addr=00000080",
                     dut_if.issue_valid, dut_if.imem_req, dut_if.imem_addr);
        end
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b1);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL collide_post cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        n_chk++;
        if (log_pc.size() == 0 || log_pc[0] !== 32'h80) begin
            n_fail++;
            $display("FAIL collide_first got=%h want=00000080", (log_pc.size() != 0) ? log_pc[0] : 32'hXXXXXXXX);
        end
    endtask

    task automatic test_random();
        bit            fl, rdy;
        logic [WS-1:0] fpc;
        rnd_lat = 1; rnd_data = 1; halt_addr = '1;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            fl  = ($urandom_range(0, 29) == 0);
            fpc = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2)) : 32'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            drive(fl, fpc, rdy);
            n_chk++;
            if (snap() !== want()) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, snap(), want()); end
            advance();
        end
        rnd_lat = 0; rnd_data = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish by 2ms");
        $fatal(1);
    end

    initial begin
        dut_if.flush       = 1'b0;
        dut_if.flush_pc    = '0;
        dut_if.issue_ready = 1'b0;
        dut_if.imem_valid  = 1'b0;
        dut_if.imem_data   = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_discard();
        test_halt();
        test_reset_mid();
        test_flush_collide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
